// File: rtl/apb_regfile_gen.sv
// apb_regfile_gen: parametrised APB slave register file.
// NUM_RW_REGS control registers followed by NUM_RO_REGS status inputs on
// word-aligned offsets from 0, with optional wait states, byte strobes and
// PSLVERR for misaligned, unmapped or read-only writes.
module apb_regfile_gen #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_RW_REGS     = 4,
  parameter int NUM_RO_REGS     = 2,
  parameter int WAIT_STATES     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0]       PADDR,
  input  logic [AMBA_WORD-1:0]             PWDATA,
  input  logic [AMBA_WORD/8-1:0]           PSTRB,
  output logic [AMBA_WORD-1:0]             PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  output logic [NUM_RW_REGS*AMBA_WORD-1:0] rw_regs,
  input  logic [NUM_RO_REGS*AMBA_WORD-1:0] ro_regs,
  output logic [NUM_RW_REGS-1:0]           wr_pulse,
  output logic                             start
);

  localparam int NB    = AMBA_WORD / 8;
  localparam int IW    = AMBA_ADDR_WIDTH - 2;
  localparam int NREGS = NUM_RW_REGS + NUM_RO_REGS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                              r_state, w_next;
  logic   [3:0]                        r_cnt, w_cnt_next;
  logic   [NUM_RW_REGS-1:0][AMBA_WORD-1:0] r_rw;
  logic   [AMBA_WORD-1:0]              r_prdata;
  logic                                r_pready, r_pslverr;
  logic   [NUM_RW_REGS-1:0]            r_pulse;

  logic   [IW-1:0]                     w_idx;
  logic                                w_err;
  logic                                w_enter_done;
  logic                                w_commit;
  logic   [AMBA_WORD-1:0]              w_rdata;

  assign w_idx = PADDR[AMBA_ADDR_WIDTH-1:2];
  assign w_err = (PADDR[1:0] != 2'b00) ||
                 (w_idx >= IW'(NREGS)) ||
                 (PWRITE && (w_idx >= IW'(NUM_RW_REGS)));

  // A write lands only on the edge leaving DONE, with the master still in access.
  assign w_commit = (r_state == S_DONE) && PSEL && PENABLE && PWRITE && !w_err;

  // Read mux over RW registers then the live status inputs.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_RW_REGS; i++)
      if (w_idx == IW'(i)) w_rdata = r_rw[i];
    for (int j = 0; j < NUM_RO_REGS; j++)
      if (w_idx == IW'(NUM_RW_REGS + j)) w_rdata = ro_regs[j*AMBA_WORD +: AMBA_WORD];
  end

  // Next-state logic: setup phase starts a transfer, wait counter gates DONE.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          if (WAIT_STATES == 0) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == 4'd0) begin
          w_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_enter_done = (r_state != S_DONE) && (w_next == S_DONE);
  end

  // State and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Response registers, loaded on the edge entering DONE so they hold for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= w_enter_done;
      r_pslverr <= w_enter_done && w_err;
      if (w_enter_done && !PWRITE)
        r_prdata <= w_err ? '0 : w_rdata;
    end
  end

  // Byte-lane register update and one-cycle write pulses (none for empty strobes).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw    <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (w_commit) begin
        for (int i = 0; i < NUM_RW_REGS; i++) begin
          if (w_idx == IW'(i)) begin
            r_pulse[i] <= |PSTRB;
            for (int b = 0; b < NB; b++)
              if (PSTRB[b]) r_rw[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign rw_regs  = r_rw;
  assign wr_pulse = r_pulse;
  assign start    = r_pulse[0];

endmodule

// File: tb/tb_apb_regfile_gen.sv
// Scoreboard bench for apb_regfile_gen: one instance with no wait states,
// one with three, sharing the address/data bus but with private PSEL/PENABLE.
module tb_apb_regfile_gen;
  localparam int W = 32, AW = 20, NRW = 4, NRO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         psel, pen;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [W-1:0]       pwdata;
  logic [3:0]         pstrb;
  logic [NRO*W-1:0]   ro;
  logic [W-1:0]       prdata  [2];
  logic               pready  [2];
  logic               pslverr [2];
  logic [NRW*W-1:0]   rwr     [2];
  logic [NRW-1:0]     wrp     [2];
  logic               strt    [2];

  apb_regfile_gen #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_RW_REGS(NRW),
                    .NUM_RO_REGS(NRO), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .rw_regs(rwr[0]), .ro_regs(ro),
    .wr_pulse(wrp[0]), .start(strt[0]));

  apb_regfile_gen #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_RW_REGS(NRW),
                    .NUM_RO_REGS(NRO), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .rw_regs(rwr[1]), .ro_regs(ro),
    .wr_pulse(wrp[1]), .start(strt[1]));

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  logic [31:0] rwm    [2][NRW];
  logic [31:0] lastrd [2];

  function automatic logic m_err(input logic wr, input logic [AW-1:0] a);
    int idx;
    idx = int'(a >> 2);
    return (a[1:0] != 2'b00) || (idx >= NRW + NRO) || (wr && idx >= NRW);
  endfunction

  function automatic logic [NRW*W-1:0] m_flat(input int k);
    logic [NRW*W-1:0] f;
    for (int i = 0; i < NRW; i++) f[i*W +: W] = rwm[k][i];
    return f;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      lastrd[k] = '0;
      for (int i = 0; i < NRW; i++) rwm[k][i] = '0;
    end
  endtask

  // One full APB transfer on instance k; expectation is queued at drive time
  // and checked when PREADY appears, followed by the post-commit cycle.
  task automatic xfer(input int k, input logic wr, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    exp_t           e;
    int             idx, lat;
    logic [NRW-1:0] ep;
    idx   = int'(a >> 2);
    e.err = m_err(wr, a);
    e.lat = (k == 0) ? 1 : 4;
    ep    = '0;
    if (!wr) begin
      if (e.err)          e.rdata = '0;
      else if (idx < NRW) e.rdata = rwm[k][idx];
      else                e.rdata = ro[(idx-NRW)*W +: W];
      lastrd[k] = e.rdata;
    end else begin
      e.rdata = lastrd[k];
      if (!e.err) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) rwm[k][idx][b*8 +: 8] = d[b*8 +: 8];
        if (s != 4'b0) ep[idx] = 1'b1;
      end
    end
    sb.push_back(e);

    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    psel[k] = 1'b1; pen[k] = 1'b0;
    @(posedge clk); #1;
    pen[k] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!pready[k]) begin
        checks++;
        if (pslverr[k] !== 1'b0) begin
          failures++;
          $display("FAIL pslverr_without_pready inst=%0d addr=%h got=%b want=0", k, a, pslverr[k]);
        end
      end
    end while (!pready[k] && lat < 20);

    e = sb.pop_front();
    checks++;
    if (pready[k] !== 1'b1) begin
      failures++;
      $display("FAIL pready_timeout inst=%0d addr=%h got=%b want=1", k, a, pready[k]);
    end else begin
      checks += 3;
      if (lat != e.lat) begin
        failures++;
        $display("FAIL latency inst=%0d addr=%h got=%0d want=%0d", k, a, lat, e.lat);
      end
      if (pslverr[k] !== e.err) begin
        failures++;
        $display("FAIL pslverr inst=%0d addr=%h got=%b want=%b", k, a, pslverr[k], e.err);
      end
      if (prdata[k] !== e.rdata) begin
        failures++;
        $display("FAIL prdata inst=%0d addr=%h wr=%b got=%h want=%h", k, a, wr, prdata[k], e.rdata);
      end
    end

    @(posedge clk); #1;
    psel[k] = 1'b0; pen[k] = 1'b0;
    @(negedge clk);
    checks += 4;
    if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0) begin
      failures++;
      $display("FAIL ready_release inst=%0d got=%b/%b want=0/0", k, pready[k], pslverr[k]);
    end
    if (wrp[k] !== ep) begin
      failures++;
      $display("FAIL wr_pulse inst=%0d addr=%h got=%b want=%b", k, a, wrp[k], ep);
    end
    if (strt[k] !== ep[0]) begin
      failures++;
      $display("FAIL start inst=%0d addr=%h got=%b want=%b", k, a, strt[k], ep[0]);
    end
    if (rwr[k] !== m_flat(k)) begin
      failures++;
      $display("FAIL rw_regs inst=%0d addr=%h got=%h want=%h", k, a, rwr[k], m_flat(k));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (prdata[k] !== '0 || pready[k] !== 1'b0 || pslverr[k] !== 1'b0 ||
          rwr[k] !== '0 || wrp[k] !== '0 || strt[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got prdata=%h rdy=%b err=%b rw=%h pulse=%b start=%b want all 0",
                 k, prdata[k], pready[k], pslverr[k], rwr[k], wrp[k], strt[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_all();
    for (int i = 0; i < NRW + NRO; i++) xfer(0, 1'b0, AW'(i*4), 32'h0, 4'h0);
    xfer(0, 1'b0, 20'h18, 32'h0, 4'h0);
  endtask

  task automatic test_write_full();
    xfer(0, 1'b1, 20'h0, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checks += 2;
    if (wrp[0] !== '0 || strt[0] !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width got=%b/%b want=0/0", wrp[0], strt[0]);
    end
    if (rwr[0][31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL ctrl_value got=%h want=deadbeef", rwr[0][31:0]);
    end
    xfer(0, 1'b0, 20'h0, 32'h0, 4'h0);
  endtask

  task automatic test_strobe();
    xfer(0, 1'b1, 20'h4, 32'hAABBCCDD, 4'hF);
    xfer(0, 1'b1, 20'h4, 32'h11223344, 4'b0101);
    checks++;
    if (rwr[0][63:32] !== 32'hAA22CC44) begin
      failures++;
      $display("FAIL strobe_merge got=%h want=aa22cc44", rwr[0][63:32]);
    end
    xfer(0, 1'b1, 20'h4, 32'hFFFFFFFF, 4'b0000);
    xfer(0, 1'b0, 20'h4, 32'h0, 4'h0);
  endtask

  task automatic test_errors();
    xfer(0, 1'b1, 20'h10, 32'h55555555, 4'hF);
    xfer(0, 1'b1, 20'h2,  32'h66666666, 4'hF);
    xfer(0, 1'b1, 20'h40, 32'h77777777, 4'hF);
    xfer(0, 1'b0, 20'h40, 32'h0, 4'h0);
    xfer(0, 1'b0, 20'h5,  32'h0, 4'h0);
  endtask

  task automatic test_wait();
    xfer(1, 1'b0, 20'h14, 32'h0, 4'h0);
    xfer(1, 1'b1, 20'h0, 32'h01020304, 4'hF);
    xfer(1, 1'b0, 20'h0, 32'h0, 4'h0);
    xfer(1, 1'b1, 20'h14, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    xfer(0, 1'b1, 20'h8, 32'hCAFEF00D, 4'hF);
    xfer(0, 1'b1, 20'hC, 32'h0BADC0DE, 4'b1100);
    xfer(0, 1'b0, 20'h8, 32'h0, 4'h0);
    xfer(0, 1'b0, 20'hC, 32'h0, 4'h0);
    xfer(0, 1'b0, 20'h10, 32'h0, 4'h0);
  endtask

  task automatic test_abort();
    // PENABLE without a preceding setup phase must be ignored.
    paddr = 20'h0; pwrite = 1'b0;
    psel[0] = 1'b1; pen[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pready[0] !== 1'b0) begin
        failures++;
        $display("FAIL enable_without_setup got=%b want=0", pready[0]);
      end
    end
    psel[0] = 1'b0; pen[0] = 1'b0;
    // Drop PSEL while waiting on the slow instance.
    paddr = 20'h8; pwrite = 1'b1; pwdata = 32'h99999999; pstrb = 4'hF;
    psel[1] = 1'b1; pen[1] = 1'b0;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; pen[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (pready[1] !== 1'b0 || wrp[1] !== '0) begin
        failures++;
        $display("FAIL abort_quiet got rdy=%b pulse=%b want 0/0", pready[1], wrp[1]);
      end
    end
    xfer(1, 1'b0, 20'h8, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    xfer(1, 1'b1, 20'h0, 32'h5A5A5A5A, 4'hF);
    paddr = 20'h8; pwrite = 1'b1; pwdata = 32'h12121212; pstrb = 4'hF;
    psel[1] = 1'b1; pen[1] = 1'b0;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    clear_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (prdata[k] !== '0 || pready[k] !== 1'b0 || pslverr[k] !== 1'b0 ||
          rwr[k] !== '0 || wrp[k] !== '0 || strt[k] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset inst=%0d got prdata=%h rdy=%b rw=%h want all 0",
                 k, prdata[k], pready[k], rwr[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    psel[1] = 1'b0; pen[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (pready[1] !== 1'b0 || rwr[1] !== '0) begin
        failures++;
        $display("FAIL post_reset_quiet got rdy=%b rw=%h want 0/0", pready[1], rwr[1]);
      end
    end
    xfer(1, 1'b0, 20'h8, 32'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; psel = '0; pen = '0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    ro = {32'h0000CAFE, 32'h12345678};
    clear_model();
    test_reset();
    test_read_all();
    test_write_full();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_wait();
    test_abort();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
